// File: rtl/ftile_ghrd_avst_rx_stats.sv
// Avalon-ST RX packet statistics: framing FSM, per-packet length, classification,
// saturating live counters and an atomic snapshot copy for CSR readback.
module ftile_ghrd_avst_rx_stats #(
  parameter int DATA_WIDTH     = 64,
  parameter int NO_OF_BYTES    = 8,
  parameter int EMPTY_BITS     = 3,
  parameter int CNT_WIDTH      = 32,
  parameter int BYTE_CNT_WIDTH = 48,
  parameter int MIN_LEN        = 64,
  parameter int MAX_LEN        = 1518
) (
  input  logic                      i_rx_clk,
  input  logic                      i_rx_rst_n,
  input  logic                      i_av_st_rx_valid,
  input  logic                      i_av_st_rx_startofpacket,
  input  logic                      i_av_st_rx_endofpacket,
  input  logic [EMPTY_BITS-1:0]     i_av_st_rx_empty,
  input  logic [5:0]                i_av_st_rx_error,
  input  logic                      i_clear,
  input  logic                      i_snapshot,
  output logic                      o_snapshot_valid,
  output logic [CNT_WIDTH-1:0]      o_pkt_good,
  output logic [CNT_WIDTH-1:0]      o_pkt_err,
  output logic [CNT_WIDTH-1:0]      o_pkt_runt,
  output logic [CNT_WIDTH-1:0]      o_pkt_oversize,
  output logic [CNT_WIDTH-1:0]      o_framing_err,
  output logic [BYTE_CNT_WIDTH-1:0] o_byte_good
);

  localparam int          BEAT_BYTES = (DATA_WIDTH / 8 == NO_OF_BYTES) ? NO_OF_BYTES : DATA_WIDTH / 8;
  localparam logic [15:0] BEAT_B     = 16'(BEAT_BYTES);
  localparam logic [15:0] MIN_L      = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L      = 16'(MAX_LEN);

  typedef enum logic {S_IDLE, S_IN_PKT} state_t;

  function automatic logic [15:0] len_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  function automatic logic [BYTE_CNT_WIDTH-1:0] byte_add(input logic [BYTE_CNT_WIDTH-1:0] c,
                                                        input logic [15:0] l);
    logic [BYTE_CNT_WIDTH:0] s;
    s = {1'b0, c} + (BYTE_CNT_WIDTH+1)'(l);
    return s[BYTE_CNT_WIDTH] ? {BYTE_CNT_WIDTH{1'b1}} : s[BYTE_CNT_WIDTH-1:0];
  endfunction

  state_t                    r_state;
  logic [15:0]               r_len;
  logic [CNT_WIDTH-1:0]      r_cnt_good, r_cnt_err, r_cnt_runt, r_cnt_over, r_cnt_frm;
  logic [BYTE_CNT_WIDTH-1:0] r_cnt_byte;
  logic [CNT_WIDTH-1:0]      r_snap_good, r_snap_err, r_snap_runt, r_snap_over, r_snap_frm;
  logic [BYTE_CNT_WIDTH-1:0] r_snap_byte;
  logic                      r_snap_vld;

  logic        w_in_pkt, w_frm, w_accept, w_done, w_has_err;
  logic [15:0] w_contrib, w_len;
  logic        w_is_err, w_is_runt, w_is_over, w_is_good;

  // A SOP beat always restarts the length, so a SOP inside a packet drops the old one.
  always_comb begin
    w_in_pkt  = (r_state == S_IN_PKT);
    w_frm     = i_av_st_rx_valid & (w_in_pkt ? i_av_st_rx_startofpacket : ~i_av_st_rx_startofpacket);
    w_accept  = i_av_st_rx_valid & (i_av_st_rx_startofpacket | w_in_pkt);
    w_done    = w_accept & i_av_st_rx_endofpacket;
    w_contrib = i_av_st_rx_endofpacket ? (BEAT_B - 16'(i_av_st_rx_empty)) : BEAT_B;
    w_len     = len_add(i_av_st_rx_startofpacket ? 16'd0 : r_len, w_contrib);
    w_has_err = |i_av_st_rx_error;
    w_is_err  = w_done & w_has_err;
    w_is_runt = w_done & ~w_has_err & (w_len < MIN_L);
    w_is_over = w_done & ~w_has_err & ~(w_len < MIN_L) & (w_len > MAX_L);
    w_is_good = w_done & ~w_has_err & ~(w_len < MIN_L) & ~(w_len > MAX_L);
  end

  always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
    if (!i_rx_rst_n) begin
      r_state <= S_IDLE;
      r_len   <= 16'd0;
    end else if (w_accept) begin
      r_state <= i_av_st_rx_endofpacket ? S_IDLE : S_IN_PKT;
      r_len   <= i_av_st_rx_endofpacket ? 16'd0 : w_len;
    end
  end

  always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
    if (!i_rx_rst_n) begin
      r_cnt_good <= '0;
      r_cnt_err  <= '0;
      r_cnt_runt <= '0;
      r_cnt_over <= '0;
      r_cnt_frm  <= '0;
      r_cnt_byte <= '0;
    end else if (i_clear) begin
      r_cnt_good <= '0;
      r_cnt_err  <= '0;
      r_cnt_runt <= '0;
      r_cnt_over <= '0;
      r_cnt_frm  <= '0;
      r_cnt_byte <= '0;
    end else begin
      if (w_is_good) begin
        r_cnt_good <= cnt_inc(r_cnt_good);
        r_cnt_byte <= byte_add(r_cnt_byte, w_len);
      end
      if (w_is_err)  r_cnt_err  <= cnt_inc(r_cnt_err);
      if (w_is_runt) r_cnt_runt <= cnt_inc(r_cnt_runt);
      if (w_is_over) r_cnt_over <= cnt_inc(r_cnt_over);
      if (w_frm)     r_cnt_frm  <= cnt_inc(r_cnt_frm);
    end
  end

  // Snapshot samples the live counters before this cycle's update or clear.
  always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
    if (!i_rx_rst_n) begin
      r_snap_vld  <= 1'b0;
      r_snap_good <= '0;
      r_snap_err  <= '0;
      r_snap_runt <= '0;
      r_snap_over <= '0;
      r_snap_frm  <= '0;
      r_snap_byte <= '0;
    end else begin
      r_snap_vld <= i_snapshot;
      if (i_snapshot) begin
        r_snap_good <= r_cnt_good;
        r_snap_err  <= r_cnt_err;
        r_snap_runt <= r_cnt_runt;
        r_snap_over <= r_cnt_over;
        r_snap_frm  <= r_cnt_frm;
        r_snap_byte <= r_cnt_byte;
      end
    end
  end

  assign o_snapshot_valid = r_snap_vld;
  assign o_pkt_good       = r_snap_good;
  assign o_pkt_err        = r_snap_err;
  assign o_pkt_runt       = r_snap_runt;
  assign o_pkt_oversize   = r_snap_over;
  assign o_framing_err    = r_snap_frm;
  assign o_byte_good      = r_snap_byte;

endmodule
